// File: rtl/ftdi_echo_engine_if.sv
// RX/TX handshake bundle between the FTDI controller and the echo engine.
// The controller side is the master; the echo engine is the slave.
interface ftdi_echo_engine_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_rx_data;
    logic              in_rx_rdy;
    logic              out_rx_ena;
    logic              out_rx_cons_rdy;
    logic [DATA_W-1:0] out_tx_data;
    logic              out_tx_data_rdy;
    logic              in_tx_ftdi_rdy;

    modport master (
        output in_rx_data,
        output in_rx_rdy,
        input  out_rx_ena,
        input  out_rx_cons_rdy,
        input  out_tx_data,
        input  out_tx_data_rdy,
        output in_tx_ftdi_rdy
    );

    modport slave (
        input  in_rx_data,
        input  in_rx_rdy,
        output out_rx_ena,
        output out_rx_cons_rdy,
        output out_tx_data,
        output out_tx_data_rdy,
        input  in_tx_ftdi_rdy
    );
endinterface

// File: rtl/ftdi_echo_engine.sv
// Half-duplex packet echo: collects PKT_LEN bytes from the FTDI controller, then
// sends them back through a per-packet transform (pass, invert-on-match, invert, reverse).
module ftdi_echo_engine #(
    parameter int                DATA_W     = 8,
    parameter int                PKT_LEN    = 5,
    parameter logic [DATA_W-1:0] MATCH_BYTE = DATA_W'(8'hAA),
    parameter int                CNT_W      = 16
) (
    input  logic              in_clk,
    input  logic              in_reset_n,
    input  logic [1:0]        in_mode,
    ftdi_echo_engine_if.slave bus,
    output logic              out_busy,
    output logic [CNT_W-1:0]  out_pkt_count
);

    localparam int IDX_W = $clog2(PKT_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(PKT_LEN);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RX_ACK  = 3'd1;
    localparam logic [2:0] ST_TX_LOAD = 3'd2;
    localparam logic [2:0] ST_TX_REQ  = 3'd3;
    localparam logic [2:0] ST_TX_ACK  = 3'd4;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_MATCH = 2'd1;
    localparam logic [1:0] MODE_INV   = 2'd2;
    localparam logic [1:0] MODE_REV   = 2'd3;

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic              buf_we;
    logic              last_byte;

    logic [DATA_W-1:0] pkt_buf [PKT_LEN];

    function automatic logic [DATA_W-1:0] transform(input logic [DATA_W-1:0] b,
                                                    input logic [1:0]        m);
        logic [DATA_W-1:0] r;
        r = b;
        case (m)
            MODE_MATCH: if (b == MATCH_BYTE) r = ~b;
            MODE_INV:   r = ~b;
            default:    r = b;
        endcase
        return r;
    endfunction

    // In reverse mode the packet ends at index 0, otherwise at the top index.
    assign last_byte = (mode_q == MODE_REV) ? (rd_idx_q == '0) : (rd_idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        mode_d      = mode_q;
        tx_data_d   = tx_data_q;
        pkt_count_d = pkt_count_q;
        buf_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_rx_rdy) begin
                    buf_we   = 1'b1;
                    if (wr_idx_q == '0) mode_d = in_mode;
                    wr_idx_d = wr_idx_q + 1'b1;
                    state_d  = ST_RX_ACK;
                end
            end
            ST_RX_ACK: begin
                if (!bus.in_rx_rdy) begin
                    if (wr_idx_q == FULL_IDX) begin
                        rd_idx_d = (mode_q == MODE_REV) ? LAST_IDX : '0;
                        state_d  = ST_TX_LOAD;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_TX_LOAD: begin
                tx_data_d = transform(pkt_buf[rd_idx_q], mode_q);
                state_d   = ST_TX_REQ;
            end
            ST_TX_REQ: begin
                if (bus.in_tx_ftdi_rdy) state_d = ST_TX_ACK;
            end
            ST_TX_ACK: begin
                if (!bus.in_tx_ftdi_rdy) begin
                    if (last_byte) begin
                        pkt_count_d = pkt_count_q + 1'b1;
                        wr_idx_d    = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        rd_idx_d = (mode_q == MODE_REV) ? rd_idx_q - 1'b1 : rd_idx_q + 1'b1;
                        state_d  = ST_TX_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q     <= ST_IDLE;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            mode_q      <= MODE_PASS;
            tx_data_q   <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            mode_q      <= mode_d;
            tx_data_q   <= tx_data_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Packet storage carries no reset; a restarted packet simply overwrites it.
    always_ff @(posedge in_clk) begin
        if (buf_we) pkt_buf[wr_idx_q] <= bus.in_rx_data;
    end

    assign bus.out_rx_ena      = (state_q == ST_IDLE);
    assign bus.out_rx_cons_rdy = (state_q == ST_RX_ACK);
    assign bus.out_tx_data_rdy = (state_q == ST_TX_REQ);
    assign bus.out_tx_data     = tx_data_q;
    assign out_busy            = (state_q != ST_IDLE);
    assign out_pkt_count       = pkt_count_q;

endmodule

// File: tb/tb_ftdi_echo_engine.sv
// Directed bench for ftdi_echo_engine: expected TX bytes go into a scoreboard queue
// and a TX responder process pops and compares each byte the engine presents.
module tb_ftdi_echo_engine;

    logic        in_clk;
    logic        in_reset_n;
    logic [1:0]  in_mode;
    logic        out_busy;
    logic [15:0] out_pkt_count;

    ftdi_echo_engine_if #(.DATA_W(8)) bus();

    ftdi_echo_engine #(
        .DATA_W     (8),
        .PKT_LEN    (5),
        .MATCH_BYTE (8'hAA),
        .CNT_W      (16)
    ) dut (
        .in_clk        (in_clk),
        .in_reset_n    (in_reset_n),
        .in_mode       (in_mode),
        .bus           (bus),
        .out_busy      (out_busy),
        .out_pkt_count (out_pkt_count)
    );

    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic [7:0] exp_q[$];
    int         ack_hold     = 1;
    logic       slow_check   = 1'b0;

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_output(input logic [7:0] act);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL tx_unexpected: got %0h, expected no byte", act);
        end else begin
            exp = exp_q.pop_front();
            check_val("tx_data", {24'd0, act}, {24'd0, exp});
        end
    endtask

    // TX responder and scoreboard monitor.
    initial begin
        logic [7:0] held;
        bus.in_tx_ftdi_rdy = 1'b0;
        forever begin
            @(negedge in_clk);
            if (bus.out_tx_data_rdy && !bus.in_tx_ftdi_rdy) begin
                check_output(bus.out_tx_data);
                check_val("rx_quiet_in_tx", {30'd0, bus.out_rx_ena, bus.out_rx_cons_rdy}, 32'd0);
                held = bus.out_tx_data;
                bus.in_tx_ftdi_rdy = 1'b1;
                for (int i = 0; i < ack_hold; i++) begin
                    @(negedge in_clk);
                    if (slow_check) begin
                        check_val("hold_data_stable", {24'd0, bus.out_tx_data}, {24'd0, held});
                        check_val("hold_rdy_low", {31'd0, bus.out_tx_data_rdy}, 32'd0);
                        check_val("hold_rx_ena_low", {31'd0, bus.out_rx_ena}, 32'd0);
                    end
                end
                bus.in_tx_ftdi_rdy = 1'b0;
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] b);
        int n;
        n = 0;
        while (!bus.out_rx_ena && n < 1000) begin
            @(negedge in_clk);
            n++;
        end
        if (n >= 1000) begin
            check_val("rx_ena_timeout", 32'd0, 32'd1);
            return;
        end
        bus.in_rx_data = b;
        bus.in_rx_rdy  = 1'b1;
        n = 0;
        do begin
            @(negedge in_clk);
            n++;
        end while (!bus.out_rx_cons_rdy && n < 1000);
        if (n >= 1000) check_val("rx_ack_timeout", 32'd0, 32'd1);
        bus.in_rx_rdy = 1'b0;
        @(negedge in_clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_busy) && n < 2000) begin
            @(negedge in_clk);
            n++;
        end
        if (n >= 2000) check_val("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_packet(input logic [1:0] mode, input logic [7:0] rx [5],
                               input logic [7:0] tx [5], input int exp_count);
        foreach (tx[i]) exp_q.push_back(tx[i]);
        in_mode = mode;
        foreach (rx[i]) apply_stimulus(rx[i]);
        wait_drain();
        check_val("pkt_count", {16'd0, out_pkt_count}, exp_count);
    endtask

    task automatic do_reset();
        @(negedge in_clk);
        in_reset_n    = 1'b0;
        bus.in_rx_rdy = 1'b0;
        #1;
        check_val("rst_rx_ena", {31'd0, bus.out_rx_ena}, 32'd1);
        check_val("rst_cons_rdy", {31'd0, bus.out_rx_cons_rdy}, 32'd0);
        check_val("rst_tx_rdy", {31'd0, bus.out_tx_data_rdy}, 32'd0);
        check_val("rst_busy", {31'd0, out_busy}, 32'd0);
        check_val("rst_tx_data", {24'd0, bus.out_tx_data}, 32'd0);
        check_val("rst_pkt_count", {16'd0, out_pkt_count}, 32'd0);
        repeat (2) @(negedge in_clk);
        in_reset_n = 1'b1;
        @(negedge in_clk);
    endtask

    initial begin
        in_reset_n    = 1'b0;
        in_mode       = 2'd0;
        bus.in_rx_data = 8'h00;
        bus.in_rx_rdy  = 1'b0;
        do_reset();

        send_packet(2'd0, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05},
                          '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 1);
        send_packet(2'd1, '{8'hAA, 8'h55, 8'hAA, 8'h00, 8'hFF},
                          '{8'h55, 8'h55, 8'h55, 8'h00, 8'hFF}, 2);
        send_packet(2'd3, '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50},
                          '{8'h50, 8'h40, 8'h30, 8'h20, 8'h10}, 3);
        send_packet(2'd2, '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50},
                          '{8'hEF, 8'hDF, 8'hCF, 8'hBF, 8'hAF}, 4);

        // Mode changes after the second byte must not affect the packet.
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        exp_q.push_back(8'h44); exp_q.push_back(8'h55);
        in_mode = 2'd0;
        apply_stimulus(8'h11);
        apply_stimulus(8'h22);
        in_mode = 2'd2;
        apply_stimulus(8'h33);
        apply_stimulus(8'h44);
        apply_stimulus(8'h55);
        wait_drain();
        check_val("pkt_count_mode_switch", {16'd0, out_pkt_count}, 32'd5);

        // Partial packet discarded by reset.
        in_mode = 2'd2;
        apply_stimulus(8'h77);
        apply_stimulus(8'h88);
        apply_stimulus(8'h99);
        do_reset();
        send_packet(2'd0, '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5},
                          '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5}, 1);

        // Slow acknowledge held for 20 cycles per byte.
        ack_hold   = 20;
        slow_check = 1'b1;
        send_packet(2'd0, '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h7E},
                          '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h7E}, 2);
        slow_check = 1'b0;
        ack_hold   = 1;

        repeat (5) @(negedge in_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
